stream_framer: RTL and testbench



---
 rtl/stream_framer_pkg.sv | 20 ++
 rtl/stream_framer_buf.sv | 27 ++
 rtl/stream_framer.sv | 168 ++++++++++++++++
 tb/tb_stream_framer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_framer_pkg.sv
// Shared definitions for the stream_framer packetiser: FSM state encoding and
// frame constants.
package stream_framer_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_DISCARD,
        ST_SYNC,
        ST_SEQ,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    // Non-payload bytes per frame: sync, sequence, length, checksum.
    localparam int unsigned FRAME_OVERHEAD    = 4;

endpackage

// File: rtl/stream_framer_buf.sv
// Payload buffer for stream_framer: DEPTH x 8 register array with synchronous
// write and asynchronous read.
module framer_buf
    import stream_framer_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_framer.sv
// Store-and-forward packetiser: buffers one AXI-Stream packet, then emits
// sync, sequence, length, payload and checksum; oversize packets are dropped.
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tdata,
    input  logic       i_tlast,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_drop
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  DEPTH_B = 8'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    count, sum, len, seq;
    logic          drop;
    logic [7:0]    rd_byte;
    logic [7:0]    chk;
    logic          rx_phase, tx_phase;
    logic          in_beat, out_beat, full, last_byte, we;

    // Handshakes decode from the state register only, keeping them free of
    // combinational paths from the opposite side's ready/valid.
    always_comb begin
        rx_phase  = (state == ST_FILL) || (state == ST_DISCARD);
        tx_phase  = !rx_phase;
        in_beat   = i_tvalid && rx_phase;
        out_beat  = i_tready && tx_phase;
        full      = (count == DEPTH_B);
        last_byte = (8'(rd_ptr) == (len - 8'd1));
        we        = in_beat && (state == ST_FILL) && !full;
        chk       = 8'd0 - (seq + len + sum);
    end

    framer_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (i_clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (i_tdata),
        .raddr (rd_ptr),
        .rdata (rd_byte)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_tready  = rx_phase;
        o_tvalid  = tx_phase;
        o_tdata   = '0;
        o_tlast   = 1'b0;
        unique case (state)
            ST_FILL: begin
                if (in_beat) begin
                    if (full) begin
                        state_nxt = i_tlast ? ST_FILL : ST_DISCARD;
                    end else if (i_tlast) begin
                        state_nxt = ST_SYNC;
                    end
                end
            end
            ST_DISCARD: begin
                if (in_beat && i_tlast) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_SYNC: begin
                o_tdata = SYNC_BYTE;
                if (out_beat) state_nxt = ST_SEQ;
            end
            ST_SEQ: begin
                o_tdata = seq;
                if (out_beat) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                o_tdata = len;
                if (out_beat) state_nxt = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                o_tdata = rd_byte;
                if (out_beat && last_byte) state_nxt = ST_CHK;
            end
            ST_CHK: begin
                o_tdata = chk;
                o_tlast = 1'b1;
                if (out_beat) state_nxt = ST_FILL;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sum    <= '0;
            len    <= '0;
            seq    <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= 1'b0;
            unique case (state)
                ST_FILL: begin
                    if (in_beat) begin
                        if (!full) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= count + 8'd1;
                            sum    <= sum + i_tdata;
                            if (i_tlast) len <= count + 8'd1;
                        end else if (i_tlast) begin
                            drop   <= 1'b1;
                            wr_ptr <= '0;
                            count  <= '0;
                            sum    <= '0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (in_beat && i_tlast) begin
                        drop   <= 1'b1;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                        sum    <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (out_beat) rd_ptr <= rd_ptr + 1'b1;
                end
                ST_CHK: begin
                    if (out_beat) begin
                        seq    <= seq + 8'd1;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                        sum    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_drop = drop;

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer (DEPTH = 4): cycle-exact vector table for the
// first two frames, then hand-written sequences for backpressure, drop and reset.
module tb_stream_framer;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [11:0] exp;   // {tready, tvalid, tlast, drop, tdata}
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_tdata = '0;
    logic       i_tlast = 1'b0;
    logic       i_tvalid = 1'b0;
    logic       o_tready;
    logic [7:0] o_tdata;
    logic       o_tlast;
    logic       o_tvalid;
    logic       i_tready = 1'b1;
    logic       o_drop;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_seen = 0;
    int vld_seen = 0;

    stream_framer #(
        .DEPTH     (4),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_drop   (o_drop)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_drop)   drop_seen++;
        if (o_tvalid) vld_seen++;
    end

    function automatic logic [11:0] outs();
        return {o_tready, o_tvalid, o_tlast, o_drop, o_tdata};
    endfunction

    function automatic vec_t mk(logic v, logic [7:0] d, logic l,
                                logic rdy, logic vld, logic lst, logic [7:0] q);
        vec_t r;
        r.v = v; r.d = d; r.l = l;
        r.exp = {rdy, vld, lst, 1'b0, q};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n  = 1'b0;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = '0;
        i_tready = 1'b1;
        #2;
        check("reset_outs", 32'(outs()), 32'h800);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_pkt(input bq_t pkt);
        for (int i = 0; i < pkt.size(); i++) begin
            int unsigned w;
            w = 0;
            i_tvalid = 1'b1;
            i_tdata  = pkt[i];
            i_tlast  = (i == pkt.size() - 1);
            @(negedge i_clk);
            while (!o_tready && w < 50) begin
                @(negedge i_clk);
                w++;
            end
            check("send_ready", 32'(o_tready), 32'd1);
            @(posedge i_clk);
            #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic recv_frame(input bq_t exp, input bit toggle);
        int          k;
        int unsigned cyc;
        bit          ph;
        k = 0; cyc = 0; ph = 1'b0;
        while (k < exp.size() && cyc < 200) begin
            i_tready = toggle ? ph : 1'b1;
            @(negedge i_clk);
            if (o_tvalid) begin
                check("rx_data", 32'(o_tdata), 32'(exp[k]));
                check("rx_last", 32'(o_tlast), 32'(k == exp.size() - 1));
                if (i_tready) k++;
            end
            @(posedge i_clk);
            #1;
            cyc++;
            ph = !ph;
        end
        check("rx_count", 32'(k), 32'(exp.size()));
        i_tready = 1'b1;
        @(negedge i_clk);
        check("rx_idle", 32'({o_tready, o_tvalid}), 32'b10);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        vec_t tbl[17];
        bq_t  p, e;
        int   d0, v0;

        // frame 1: 01 02 03 -> A5 00 03 01 02 03 F7; frame 2: 10 -> A5 01 01 10 EE
        tbl[0]  = mk(1, 8'h01, 0, 1, 0, 0, 8'h00);
        tbl[1]  = mk(1, 8'h02, 0, 1, 0, 0, 8'h00);
        tbl[2]  = mk(1, 8'h03, 1, 1, 0, 0, 8'h00);
        tbl[3]  = mk(0, 8'h00, 0, 0, 1, 0, 8'hA5);
        tbl[4]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h00);
        tbl[5]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h03);
        tbl[6]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h01);
        tbl[7]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h02);
        tbl[8]  = mk(0, 8'h00, 0, 0, 1, 0, 8'h03);
        tbl[9]  = mk(0, 8'h00, 0, 0, 1, 1, 8'hF7);
        tbl[10] = mk(1, 8'h10, 1, 1, 0, 0, 8'h00);
        tbl[11] = mk(0, 8'h00, 0, 0, 1, 0, 8'hA5);
        tbl[12] = mk(0, 8'h00, 0, 0, 1, 0, 8'h01);
        tbl[13] = mk(0, 8'h00, 0, 0, 1, 0, 8'h01);
        tbl[14] = mk(0, 8'h00, 0, 0, 1, 0, 8'h10);
        tbl[15] = mk(0, 8'h00, 0, 0, 1, 1, 8'hEE);
        tbl[16] = mk(0, 8'h00, 0, 1, 0, 0, 8'h00);

        #2;
        check("por_outs", 32'(outs()), 32'h800);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            i_tvalid = tbl[i].v;
            i_tdata  = tbl[i].d;
            i_tlast  = tbl[i].l;
            i_tready = 1'b1;
            @(negedge i_clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            @(posedge i_clk);
            #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;

        // backpressure: ready toggles every cycle, frame identical to frame 1
        do_reset();
        p = '{8'h01, 8'h02, 8'h03};
        e = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
        send_pkt(p);
        recv_frame(e, 1'b1);

        // oversize: 6 bytes, then 5 bytes ending exactly one past DEPTH
        do_reset();
        d0 = drop_seen; v0 = vld_seen;
        p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(p);
        @(negedge i_clk);
        check("drop6_pulse", 32'({o_drop, o_tvalid, o_tready}), 32'b101);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("drop6_clear", 32'(o_drop), 32'd0);
        @(posedge i_clk);
        #1;
        p = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_pkt(p);
        @(negedge i_clk);
        check("drop5_pulse", 32'({o_drop, o_tvalid, o_tready}), 32'b101);
        @(posedge i_clk);
        #1;
        check("drop_count", 32'(drop_seen - d0), 32'd2);
        check("drop_no_tx", 32'(vld_seen - v0), 32'd0);
        p = '{8'h01};
        e = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'hFE};
        send_pkt(p);
        recv_frame(e, 1'b0);

        // exactly DEPTH bytes
        do_reset();
        d0 = drop_seen;
        p = '{8'h01, 8'h01, 8'h01, 8'h01};
        e = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h01, 8'h01, 8'h01, 8'hF8};
        send_pkt(p);
        recv_frame(e, 1'b0);
        check("full_no_drop", 32'(drop_seen - d0), 32'd0);

        // asynchronous reset in the middle of the payload
        do_reset();
        p = '{8'h01, 8'h02, 8'h03};
        send_pkt(p);
        i_tready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("mid_payload", 32'({o_tvalid, o_tdata}), 32'h102);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'h800);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        p = '{8'h05};
        e = '{8'hA5, 8'h00, 8'h01, 8'h05, 8'hFA};
        send_pkt(p);
        recv_frame(e, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
